// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver for 8N1-style frames.
// The asynchronous line is synchronised and edge-detected. A start edge is
// confirmed at mid start bit, then each data bit is sampled mid-bit (LSB
// first) and the stop bit is checked. A good frame updates o_data_out with a
// one-clock o_rx_done strobe. A low stop bit gives a one-clock o_frame_error
// strobe instead.
module uart_rx #(
   parameter int WIDTH_WORD    = 8,
   parameter int CANT_BIT_STOP = 1,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_rate,
   input  logic                  i_bit_rx,
   output logic [WIDTH_WORD-1:0] o_data_out,
   output logic                  o_rx_done,
   output logic                  o_frame_error
);

   // Counter widths. Each width is at least one bit, so degenerate
   // parameter values still elaborate.
   localparam int TICK_SPAN = TICKS_PER_BIT * CANT_BIT_STOP;
   localparam int TICK_W    = (TICK_SPAN > 2)  ? $clog2(TICK_SPAN)  : 1;
   localparam int BIT_W     = (WIDTH_WORD > 2) ? $clog2(WIDTH_WORD) : 1;

   // Tick-count compare points: mid start bit, end of one bit, end of the
   // stop field.
   localparam logic [TICK_W-1:0] TICK_HALF      = TICK_W'(TICKS_PER_BIT / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_BIT_LAST  = TICK_W'(TICKS_PER_BIT - 1);
   localparam logic [TICK_W-1:0] TICK_STOP_LAST = TICK_W'(TICK_SPAN - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(WIDTH_WORD - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // Synchroniser and edge-detect flops.
   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic                  prev_q,  prev_d;

   // FSM and datapath flops.
   state_t                state_q, state_d;
   logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [WIDTH_WORD-1:0] shift_q, shift_d;

   // Registered outputs.
   logic [WIDTH_WORD-1:0] data_out_q, data_out_d;
   logic                  rx_done_q, rx_done_d;
   logic                  frame_err_q, frame_err_d;

   // Decoded conditions.
   logic                  rx_s;
   logic                  fall_s;
   logic                  stop_tick_s;

   assign rx_s        = sync2_q;
   assign fall_s      = prev_q & ~rx_s;
   assign stop_tick_s = (state_q == ST_STOP) && i_rate && (tick_cnt_q == TICK_STOP_LAST);

   // State register: every flop in the block, with synchronous reset.
   // The synchroniser resets to the idle (high) line level.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         state_q     <= ST_IDLE;
         tick_cnt_q  <= {TICK_W{1'b0}};
         bit_cnt_q   <= {BIT_W{1'b0}};
         shift_q     <= {WIDTH_WORD{1'b0}};
         data_out_q  <= {WIDTH_WORD{1'b0}};
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_out_q  <= data_out_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next state: synchroniser chain, FSM transitions, counters and shifter.
   always_comb begin
      sync1_d    = i_bit_rx;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;

      case (state_q)
         ST_IDLE: begin
            // Only a real 1->0 transition arms the receiver. A line held low
            // (break) never re-arms it. A tick in this cycle is not counted.
            tick_cnt_d = {TICK_W{1'b0}};
            bit_cnt_d  = {BIT_W{1'b0}};
            if (fall_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            if (i_rate) begin
               if (tick_cnt_q == TICK_HALF) begin
                  tick_cnt_d = {TICK_W{1'b0}};
                  bit_cnt_d  = {BIT_W{1'b0}};
                  if (!rx_s) begin
                     state_d = ST_DATA;
                  end else begin
                     // The line is high again at mid start bit: treat it as a glitch.
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end else begin
               tick_cnt_d = tick_cnt_q;
            end
         end

         ST_DATA: begin
            if (i_rate) begin
               if (tick_cnt_q == TICK_BIT_LAST) begin
                  // Mid-bit sample. LSB arrives first, so shift right.
                  tick_cnt_d = {TICK_W{1'b0}};
                  shift_d    = {rx_s, shift_q[WIDTH_WORD-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end else begin
               tick_cnt_d = tick_cnt_q;
            end
         end

         ST_STOP: begin
            if (i_rate) begin
               if (tick_cnt_q == TICK_STOP_LAST) begin
                  state_d    = ST_IDLE;
                  tick_cnt_d = {TICK_W{1'b0}};
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end else begin
               tick_cnt_d = tick_cnt_q;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            tick_cnt_d = {TICK_W{1'b0}};
            bit_cnt_d  = {BIT_W{1'b0}};
         end
      endcase
   end

   // Output logic: on the stop sample, publish the word or flag a framing
   // error. The two strobes are mutually exclusive by construction.
   always_comb begin
      data_out_d  = data_out_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      if (stop_tick_s) begin
         if (rx_s) begin
            data_out_d = shift_q;
            rx_done_d  = 1'b1;
         end else begin
            frame_err_d = 1'b1;
         end
      end else begin
         data_out_d = data_out_q;
      end
   end

   assign o_data_out    = data_out_q;
   assign o_rx_done     = rx_done_q;
   assign o_frame_error = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx. The oversampling tick arrives every 4
// clocks, so one bit lasts 64 clocks. Inputs change on the falling edge.
// A monitor samples the DUT 1 time unit after each rising edge.
module tb_uart_rx;

   logic       clk;
   logic       i_reset;
   logic       i_rate;
   logic       i_bit_rx;
   logic [7:0] o_data_out;
   logic       o_rx_done;
   logic       o_frame_error;

   int vectors     = 0;
   int miscompares = 0;

   // Monitor state.
   int         tick_total = 0;
   int         done_cnt   = 0;
   int         fe_cnt     = 0;
   int         both_cnt   = 0;
   int         rst_bad    = 0;
   logic [7:0] data_hist [0:15];
   int         done_tick_hist [0:15];

   logic [1:0] rate_div = 2'd0;

   uart_rx #(
      .WIDTH_WORD   (8),
      .CANT_BIT_STOP(1),
      .TICKS_PER_BIT(16)
   ) dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_rate       (i_rate),
      .i_bit_rx     (i_bit_rx),
      .o_data_out   (o_data_out),
      .o_rx_done    (o_rx_done),
      .o_frame_error(o_frame_error)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversampling tick: high for one clock in every four.
   initial begin
      i_rate = 1'b0;
      forever begin
         @(negedge clk);
         rate_div = rate_div + 2'd1;
         i_rate   = (rate_div == 2'd0);
      end
   end

   // Monitor: count ticks and strobes, and log each received word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (i_rate) tick_total++;
         if (o_rx_done === 1'b1) begin
            data_hist[done_cnt[3:0]]      = o_data_out;
            done_tick_hist[done_cnt[3:0]] = tick_total;
            done_cnt++;
         end
         if (o_frame_error === 1'b1) fe_cnt++;
         if (o_rx_done === 1'b1 && o_frame_error === 1'b1) both_cnt++;
         if (i_reset === 1'b1 &&
             (o_data_out !== 8'h00 || o_rx_done !== 1'b0 || o_frame_error !== 1'b0))
            rst_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Send one frame: start bit, 8 data bits LSB first, then the given stop level.
   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      i_bit_rx = 1'b0;
      wait_clks(64);
      for (int i = 0; i < 8; i++) begin
         i_bit_rx = d[i];
         wait_clks(64);
      end
      i_bit_rx = stop_b;
      wait_clks(64);
   endtask

   int         base_done;
   int         base_fe;
   int         t0;
   int         lat;
   logic [7:0] c3;

   initial begin
      i_reset  = 1'b1;
      i_bit_rx = 1'b1;
      c3       = 8'hC3;
      @(negedge clk);

      // 1. Reset with the line toggling, then a long idle-high line.
      for (int i = 0; i < 3; i++) begin
         i_bit_rx = ~i_bit_rx;
         @(negedge clk);
      end
      i_bit_rx = 1'b1;
      i_reset  = 1'b0;
      wait_clks(2000);
      chk("rst_outputs_zero_during_reset", rst_bad, 0);
      chk("rst_no_done", done_cnt, 0);
      chk("rst_no_frame_err", fe_cnt, 0);
      chk("rst_data_zero", {24'h0, o_data_out}, 32'h00);

      // 2. Single frame 0xA5 with a latency check.
      base_done = done_cnt;
      base_fe   = fe_cnt;
      t0        = tick_total;
      send_frame(8'hA5, 1'b1);
      wait_clks(64);
      chk("single_done_count", done_cnt - base_done, 1);
      chk("single_data_log", {24'h0, data_hist[base_done[3:0]]}, 32'hA5);
      chk("single_data_out", {24'h0, o_data_out}, 32'hA5);
      chk("single_no_frame_err", fe_cnt - base_fe, 0);
      lat = done_tick_hist[base_done[3:0]] - t0;
      chk("single_latency_ticks_152_153", {31'h0, (lat >= 152 && lat <= 153)}, 32'h1);

      // 3. Back-to-back frames 0x00 then 0xFF with no idle gap.
      base_done = done_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_clks(64);
      chk("b2b_done_count", done_cnt - base_done, 2);
      chk("b2b_first_data", {24'h0, data_hist[base_done[3:0]]}, 32'h00);
      chk("b2b_second_data", {24'h0, data_hist[(base_done + 1) % 16]}, 32'hFF);
      chk("b2b_no_frame_err", fe_cnt - base_fe, 0);

      // 4. Start glitch of 3 ticks, then frame 0x3C.
      base_done = done_cnt;
      i_bit_rx  = 1'b0;
      wait_clks(12);
      i_bit_rx  = 1'b1;
      wait_clks(200);
      chk("glitch_no_done", done_cnt - base_done, 0);
      send_frame(8'h3C, 1'b1);
      wait_clks(64);
      chk("glitch_then_done", done_cnt - base_done, 1);
      chk("glitch_then_data", {24'h0, o_data_out}, 32'h3C);
      chk("glitch_no_frame_err", fe_cnt - base_fe, 0);

      // 5. Framing error on 0x55, then a break held low, then 0x81.
      base_done = done_cnt;
      send_frame(8'h55, 1'b0);
      wait_clks(1000);
      chk("ferr_one_pulse", fe_cnt - base_fe, 1);
      chk("ferr_no_done", done_cnt - base_done, 0);
      chk("ferr_data_kept", {24'h0, o_data_out}, 32'h3C);
      i_bit_rx = 1'b1;
      wait_clks(200);
      chk("break_no_more_strobes", (fe_cnt - base_fe) + (done_cnt - base_done), 1);
      send_frame(8'h81, 1'b1);
      wait_clks(64);
      chk("after_break_done", done_cnt - base_done, 1);
      chk("after_break_data", {24'h0, o_data_out}, 32'h81);
      base_fe = fe_cnt;

      // 6. Reset during bit 4 of 0xC3, then frame 0x12.
      base_done = done_cnt;
      i_bit_rx  = 1'b0;
      wait_clks(64);
      for (int i = 0; i < 4; i++) begin
         i_bit_rx = c3[i];
         wait_clks(64);
      end
      i_bit_rx = c3[4];
      wait_clks(32);
      i_reset  = 1'b1;
      i_bit_rx = 1'b1;
      wait_clks(3);
      chk("midrst_data_zero_in_reset", {24'h0, o_data_out}, 32'h00);
      i_reset = 1'b0;
      wait_clks(300);
      chk("midrst_no_done", done_cnt - base_done, 0);
      chk("midrst_no_frame_err", fe_cnt - base_fe, 0);
      chk("midrst_data_zero", {24'h0, o_data_out}, 32'h00);
      send_frame(8'h12, 1'b1);
      wait_clks(64);
      chk("midrst_then_done", done_cnt - base_done, 1);
      chk("midrst_then_data", {24'h0, o_data_out}, 32'h12);

      // Strobes must never overlap anywhere in the run.
      chk("never_both_strobes", both_cnt, 0);
      chk("rst_outputs_zero_all_resets", rst_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
